// File: rtl/sevenseg_scan_decoder_pkg.sv
// Shared constants for the seven-segment scan monitor: segment bit indices,
// hex glyph table, chase ring length and FSM state encoding.
package sevenseg_scan_decoder_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam int CHASE_LEN = 6;

    // Lit-segment glyphs {g,f,e,d,c,b,a}, entry n is hex digit n (b and d lowercase).
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } scan_state_e;

    function automatic logic [2:0] ring_next(input logic [2:0] pos);
        return (pos == 3'(CHASE_LEN - 1)) ? 3'd0 : pos + 3'd1;
    endfunction

    function automatic logic [2:0] ring_prev(input logic [2:0] pos);
        return (pos == 3'd0) ? 3'(CHASE_LEN - 1) : pos - 3'd1;
    endfunction

endpackage

// File: rtl/sevenseg_scan_decoder_if.sv
// Bus between the display-driver pins and the scan monitor; the driver side
// (or a testbench) is the master, the monitor is the slave.
interface sevenseg_scan_decoder_if #(
    parameter int PERIOD_W = 26
);
    logic [7:0]          seg_n;
    logic [3:0]          an_n;
    logic [15:0]         digit_val;
    logic [3:0]          digit_valid;
    logic [3:0]          digit_dp;
    logic                update;
    logic                chase_valid;
    logic [2:0]          chase_pos;
    logic                chase_step;
    logic                chase_dir;
    logic [PERIOD_W-1:0] chase_period;

    modport master (
        output seg_n, an_n,
        input  digit_val, digit_valid, digit_dp, update,
        input  chase_valid, chase_pos, chase_step, chase_dir, chase_period
    );

    modport slave (
        input  seg_n, an_n,
        output digit_val, digit_valid, digit_dp, update,
        output chase_valid, chase_pos, chase_step, chase_dir, chase_period
    );
endinterface

// File: rtl/sevenseg_glyph_decode.sv
// Combinational decode of one active-low segment word into hex value,
// decimal point and single-segment chase position.
import sevenseg_scan_decoder_pkg::*;

module sevenseg_glyph_decode (
    input  logic [7:0] i_seg_n,
    output logic [3:0] o_val,
    output logic       o_valid,
    output logic       o_dp,
    output logic       o_chase_hit,
    output logic [2:0] o_chase_idx
);

    logic [6:0] w_lit;
    logic [2:0] w_lit_cnt;

    assign w_lit = ~i_seg_n[SEG_G:SEG_A];
    assign o_dp  = ~i_seg_n[SEG_DP];

    always_comb begin
        o_val   = 4'd0;
        o_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (w_lit == HEX_GLYPH[i]) begin
                o_val   = 4'(i);
                o_valid = 1'b1;
            end
        end
    end

    // Index is only meaningful when exactly one ring segment is lit.
    always_comb begin
        w_lit_cnt   = 3'd0;
        o_chase_idx = 3'd0;
        for (int i = 0; i < CHASE_LEN; i++) begin
            if (w_lit[i]) begin
                w_lit_cnt   = w_lit_cnt + 3'd1;
                o_chase_idx = 3'(i);
            end
        end
    end

    assign o_chase_hit = (w_lit_cnt == 3'd1) && !w_lit[SEG_G];

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Seven-segment scan monitor: debounces {an_n, seg_n}, commits stable patterns
// to per-digit hex registers and tracks the chase ring. SEVENSEG_SYNC_EN adds a 2-flop input synchronizer.
//
// state | meaning
// IDLE  | all digit enables off, nothing to track
// TRACK | counting identical samples towards a commit
// HOLD  | pattern committed, waiting for the bus to change
import sevenseg_scan_decoder_pkg::*;

module sevenseg_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int PERIOD_W      = 26
) (
    input  logic                   inclk,
    input  logic                   res_n,
    sevenseg_scan_decoder_if.slave bus
);

    localparam logic [7:0]          CNT_LAST   = 8'(STABLE_CYCLES - 2);
    localparam logic [PERIOD_W-1:0] PERIOD_ONE = 1;

    logic [11:0]         w_sample;
    logic [3:0]          w_an_n;
    logic [7:0]          w_seg_n;
    logic                w_all_off;
    logic                w_same;

    logic [11:0]         r_prev;
    scan_state_e         r_state;
    scan_state_e         w_state_nxt;
    logic [7:0]          r_cnt;
    logic                w_commit;
    logic                w_cnt_clr;

    logic [3:0]          w_glyph_val;
    logic                w_glyph_valid;
    logic                w_glyph_dp;
    logic                w_chase_hit;
    logic [2:0]          w_chase_idx;
    logic                w_step_fwd;
    logic                w_step_rev;
    logic [PERIOD_W-1:0] w_period_inc;

    logic [15:0]         r_digit_val;
    logic [3:0]          r_digit_valid;
    logic [3:0]          r_digit_dp;
    logic                r_update;
    logic                r_chase_valid;
    logic [2:0]          r_chase_pos;
    logic                r_chase_step;
    logic                r_chase_dir;
    logic [PERIOD_W-1:0] r_chase_period;
    logic [PERIOD_W-1:0] r_period_cnt;

`ifdef SEVENSEG_SYNC_EN
    logic [11:0] r_sync1;
    logic [11:0] r_sync2;

    always_ff @(posedge inclk or negedge res_n) begin
        if (!res_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= {bus.an_n, bus.seg_n};
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2;
`else
    assign w_sample = {bus.an_n, bus.seg_n};
`endif

    assign w_an_n    = w_sample[11:8];
    assign w_seg_n   = w_sample[7:0];
    assign w_all_off = &w_an_n;
    assign w_same    = (w_sample == r_prev);

    always_ff @(posedge inclk or negedge res_n) begin
        if (!res_n) begin
            r_prev <= '1;
        end else begin
            r_prev <= w_sample;
        end
    end

    always_ff @(posedge inclk or negedge res_n) begin
        if (!res_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_all_off) begin
                    w_state_nxt = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (w_all_off) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_same && (r_cnt == CNT_LAST)) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!w_same) begin
                    w_state_nxt = w_all_off ? ST_IDLE : ST_TRACK;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The sample that causes a change is the first of the new run, so the count restarts at 0.
    always_comb begin
        w_commit  = 1'b0;
        w_cnt_clr = 1'b1;
        if ((r_state == ST_TRACK) && !w_all_off && w_same) begin
            if (r_cnt == CNT_LAST) begin
                w_commit = 1'b1;
            end else begin
                w_cnt_clr = 1'b0;
            end
        end
    end

    always_ff @(posedge inclk or negedge res_n) begin
        if (!res_n) begin
            r_cnt <= 8'd0;
        end else if (w_cnt_clr) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    sevenseg_glyph_decode u_glyph (
        .i_seg_n     (w_seg_n),
        .o_val       (w_glyph_val),
        .o_valid     (w_glyph_valid),
        .o_dp        (w_glyph_dp),
        .o_chase_hit (w_chase_hit),
        .o_chase_idx (w_chase_idx)
    );

    // A step needs two consecutive chase commits one ring position apart.
    assign w_step_fwd = w_commit && w_chase_hit && r_chase_valid &&
                        (w_chase_idx == ring_prev(r_chase_pos));
    assign w_step_rev = w_commit && w_chase_hit && r_chase_valid &&
                        (w_chase_idx == ring_next(r_chase_pos));

    always_ff @(posedge inclk or negedge res_n) begin
        if (!res_n) begin
            r_digit_val   <= 16'd0;
            r_digit_valid <= 4'd0;
            r_digit_dp    <= 4'd0;
            r_update      <= 1'b0;
            r_chase_valid <= 1'b0;
            r_chase_pos   <= 3'd0;
            r_chase_step  <= 1'b0;
            r_chase_dir   <= 1'b1;
        end else begin
            r_update     <= w_commit;
            r_chase_step <= w_step_fwd || w_step_rev;
            if (w_commit) begin
                for (int k = 0; k < 4; k++) begin
                    if (!w_an_n[k]) begin
                        r_digit_val[4*k +: 4] <= w_glyph_val;
                        r_digit_valid[k]      <= w_glyph_valid;
                        r_digit_dp[k]         <= w_glyph_dp;
                    end
                end
                r_chase_valid <= w_chase_hit;
                if (w_chase_hit) begin
                    r_chase_pos <= w_chase_idx;
                end
                if (w_step_fwd) begin
                    r_chase_dir <= 1'b1;
                end else if (w_step_rev) begin
                    r_chase_dir <= 1'b0;
                end
            end
        end
    end

    assign w_period_inc = (r_period_cnt == '1) ? r_period_cnt : r_period_cnt + PERIOD_ONE;

    always_ff @(posedge inclk or negedge res_n) begin
        if (!res_n) begin
            r_period_cnt   <= '0;
            r_chase_period <= '0;
        end else if (w_step_fwd || w_step_rev) begin
            r_chase_period <= w_period_inc;
            r_period_cnt   <= '0;
        end else begin
            r_period_cnt   <= w_period_inc;
        end
    end

    assign bus.digit_val    = r_digit_val;
    assign bus.digit_valid  = r_digit_valid;
    assign bus.digit_dp     = r_digit_dp;
    assign bus.update       = r_update;
    assign bus.chase_valid  = r_chase_valid;
    assign bus.chase_pos    = r_chase_pos;
    assign bus.chase_step   = r_chase_step;
    assign bus.chase_dir    = r_chase_dir;
    assign bus.chase_period = r_chase_period;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Self-checking bench for sevenseg_scan_decoder: vector table plus scoreboard
// of expected commits, and directed glitch / reset-mid-count sequences.
module tb_sevenseg_scan_decoder;

    localparam int STABLE = 4;
`ifdef SEVENSEG_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    typedef struct {
        logic [3:0] an_n;
        logic [7:0] seg_n;
        int         hold;
        logic       commit;
        logic [3:0] hex;
        logic       valid;
        logic       dp;
        logic       cv;
        logic [2:0] pos;
        logic       step;
        logic       dir;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [15:0] val;
        logic [3:0]  valid;
        logic [3:0]  dp;
        logic        cv;
        logic [2:0]  pos;
        logic        step;
        logic        dir;
    } exp_t;

    logic inclk = 1'b0;
    logic res_n = 1'b0;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_updates = 0;
    exp_t q[$];
    vec_t vecs[18];

    logic [15:0] m_val;
    logic [3:0]  m_valid;
    logic [3:0]  m_dp;

    sevenseg_scan_decoder_if #(.PERIOD_W(26)) bus ();

    sevenseg_scan_decoder #(.STABLE_CYCLES(STABLE), .PERIOD_W(26)) dut (
        .inclk (inclk),
        .res_n (res_n),
        .bus   (bus)
    );

    always #5 inclk = ~inclk;
    always @(posedge inclk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [3:0] an, input logic [3:0] hex, input logic valid,
                            input logic dp, input logic cv, input logic [2:0] pos,
                            input logic step, input logic dir);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (!an[k]) begin
                m_val[4*k +: 4] = hex;
                m_valid[k]      = valid;
                m_dp[k]         = dp;
            end
        end
        e.cyc = cyc + STABLE + SYNC_LAT;
        e.val = m_val; e.valid = m_valid; e.dp = m_dp;
        e.cv = cv; e.pos = pos; e.step = step; e.dir = dir;
        q.push_back(e);
    endtask

    task automatic apply(input logic [3:0] an, input logic [7:0] seg, input int hold);
        bus.an_n  = an;
        bus.seg_n = seg;
        repeat (hold) @(negedge inclk);
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].commit)
                push_exp(vecs[i].an_n, vecs[i].hex, vecs[i].valid, vecs[i].dp,
                         vecs[i].cv, vecs[i].pos, vecs[i].step, vecs[i].dir);
            apply(vecs[i].an_n, vecs[i].seg_n, vecs[i].hold);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digit_val"},    32'(bus.digit_val),    32'h0);
        check({tag, "_digit_valid"},  32'(bus.digit_valid),  32'h0);
        check({tag, "_digit_dp"},     32'(bus.digit_dp),     32'h0);
        check({tag, "_update"},       32'(bus.update),       32'h0);
        check({tag, "_chase_valid"},  32'(bus.chase_valid),  32'h0);
        check({tag, "_chase_pos"},    32'(bus.chase_pos),    32'h0);
        check({tag, "_chase_step"},   32'(bus.chase_step),   32'h0);
        check({tag, "_chase_dir"},    32'(bus.chase_dir),    32'h1);
        check({tag, "_chase_period"}, 32'(bus.chase_period), 32'h0);
    endtask

    // Scoreboard: every update pulse is matched against the oldest expected commit.
    always @(negedge inclk) begin
        if (res_n && bus.update) begin
            exp_t e;
            n_updates++;
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_update: got update at cycle %0d, expected none", cyc);
            end else begin
                e = q.pop_front();
                check("commit_latency", 32'(cyc),              32'(e.cyc));
                check("digit_val",      32'(bus.digit_val),    32'(e.val));
                check("digit_valid",    32'(bus.digit_valid),  32'(e.valid));
                check("digit_dp",       32'(bus.digit_dp),     32'(e.dp));
                check("chase_valid",    32'(bus.chase_valid),  32'(e.cv));
                check("chase_pos",      32'(bus.chase_pos),    32'(e.pos));
                check("chase_step",     32'(bus.chase_step),   32'(e.step));
                check("chase_dir",      32'(bus.chase_dir),    32'(e.dir));
            end
        end
    end

    initial begin
        int upd0;
        //          an_n     seg_n  hold commit hex  vld  dp   cv   pos   step dir
        vecs[0]  = '{4'b0111, 8'h82, 6,  1'b1, 4'h6, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
        vecs[1]  = '{4'b1111, 8'hFF, 3,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
        vecs[2]  = '{4'b1110, 8'hFE, 10, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1};
        vecs[3]  = '{4'b1110, 8'hDF, 10, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1};
        vecs[4]  = '{4'b1110, 8'hEF, 10, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1};
        vecs[5]  = '{4'b1110, 8'hF7, 10, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1};
        vecs[6]  = '{4'b1110, 8'hFB, 10, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1};
        vecs[7]  = '{4'b1110, 8'hFD, 10, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1};
        vecs[8]  = '{4'b1110, 8'hFE, 7,  1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1};
        vecs[9]  = '{4'b1110, 8'hFD, 10, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0};
        vecs[10] = '{4'b1110, 8'hF7, 10, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0};
        vecs[11] = '{4'b1111, 8'hFF, 3,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0};
        vecs[12] = '{4'b1000, 8'h00, 6,  1'b1, 4'h8, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0};
        vecs[13] = '{4'b1000, 8'hF6, 6,  1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0};
        vecs[14] = '{4'b1110, 8'hF9, 6,  1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0};
        vecs[15] = '{4'b1101, 8'hF9, 6,  1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0};
        vecs[16] = '{4'b0111, 8'h21, 6,  1'b1, 4'hD, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0};
        vecs[17] = '{4'b1011, 8'h83, 6,  1'b1, 4'hB, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0};

        m_val = 16'h0; m_valid = 4'h0; m_dp = 4'h0;
        bus.an_n  = 4'hF;
        bus.seg_n = 8'hFF;
        repeat (3) @(negedge inclk);
        check_reset_outputs("reset");
        res_n = 1'b1;
        repeat (3) @(negedge inclk);
        check_reset_outputs("post_release");

        run_vectors(0, 7);
        check("fwd_period", 32'(bus.chase_period), 32'd10);
        run_vectors(8, 17);
        check("rev_period", 32'(bus.chase_period), 32'd7);

        // Glitch one cycle before threshold must suppress the commit.
        apply(4'hF, 8'hFF, 4);
        upd0 = n_updates;
        apply(4'b0111, 8'h82, 3);
        apply(4'b0111, 8'h92, 1);
        repeat (SYNC_LAT + 1) @(negedge inclk);
        check("glitch_no_update", 32'(n_updates), 32'(upd0));
        push_exp(4'b0111, 4'h6, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
        apply(4'b0111, 8'h82, 6 + SYNC_LAT);
        check("glitch_one_update", 32'(n_updates), 32'(upd0 + 1));

        // Reset while counting drops the pending commit; a full run is needed afterwards.
        apply(4'hF, 8'hFF, 4);
        upd0 = n_updates;
        apply(4'b1110, 8'hC0, 3);
        res_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        m_val = 16'h0; m_valid = 4'h0; m_dp = 4'h0;
        repeat (2) @(negedge inclk);
        check("mid_reset_no_update", 32'(n_updates), 32'(upd0));
        push_exp(4'b1110, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        res_n = 1'b1;
        repeat (STABLE + SYNC_LAT - 1) @(negedge inclk);
        check("release_no_early_commit", 32'(n_updates), 32'(upd0));
        repeat (4) @(negedge inclk);
        check("release_commit", 32'(n_updates), 32'(upd0 + 1));

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
